// File: rtl/leg_pkg.sv
// Shared types for the rename/retire path: tag and arch widths, queue entry
// layout, and retire-queue state encoding.
package leg_pkg;
    localparam int DEPTH  = 16;
    localparam int TAG_W  = 9;
    localparam int ARCH_W = 5;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [ARCH_W-1:0] arch_t;
    typedef logic [IDX_W-1:0]  rob_id_t;
    typedef logic [IDX_W:0]    rob_ptr_t;

    typedef struct packed {
        logic  has_dst;
        arch_t arch;
        tag_t  new_tag;
        tag_t  old_tag;
    } rob_entry_t;

    typedef enum logic {
        TQ_RUN   = 1'b0,
        TQ_FLUSH = 1'b1
    } tq_state_e;
endpackage

// File: rtl/tag_retire_queue_ptr.sv
// Wrap-bit ring pointer: low bits index the slot, MSB flips on each wrap so
// equal indices can be told apart as full or empty.
module tq_ptr #(
    parameter int IDX_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           inc,
    input  logic           dec,
    output logic [IDX_W:0] ptr
);
    localparam int PW = IDX_W + 1;

    logic [IDX_W:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q + PW'(inc) - PW'(dec);
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/tag_retire_queue.sv
// In-order retire queue for renamed destinations: retires completed entries from
// the head, returning old tags; on flush walks back from the tail returning new tags.
module tag_retire_queue
    import leg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_dst,
    input  logic [ARCH_W-1:0] alloc_arch,
    input  logic [TAG_W-1:0]  alloc_new_tag,
    input  logic [TAG_W-1:0]  alloc_old_tag,
    output logic [IDX_W-1:0]  alloc_id,
    input  logic              done_valid,
    input  logic [IDX_W-1:0]  done_id,
    input  logic              flush,
    output logic              free_valid,
    input  logic              free_ready,
    output logic [TAG_W-1:0]  free_tag,
    output logic              commit_valid,
    output logic [ARCH_W-1:0] commit_arch,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [IDX_W:0]    count,
    output logic              empty,
    output logic              full,
    output tq_state_e         dbg_state
);
    localparam int CW = IDX_W + 1;

    // Handshakes: alloc and free transfer on a cycle where valid && ready;
    // valid never depends on ready, and a held free offer keeps its tag stable.

    rob_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
    tq_state_e         state_q, state_d;
    rob_ptr_t          head_ptr, tail_ptr;
    rob_id_t           head_idx, tail_idx, walk_idx;
    rob_entry_t        head_ent;
    logic              in_run, head_ready, walk_active, walk_has_dst;
    logic              retire, walk_step, alloc_fire;
    logic [IDX_W:0]    count_d;

    tq_ptr #(.IDX_W(IDX_W)) u_head (
        .clk(clk), .reset(reset), .inc(retire), .dec(1'b0), .ptr(head_ptr)
    );
    tq_ptr #(.IDX_W(IDX_W)) u_tail (
        .clk(clk), .reset(reset), .inc(alloc_fire), .dec(walk_step), .ptr(tail_ptr)
    );

    assign head_idx = head_ptr[IDX_W-1:0];
    assign tail_idx = tail_ptr[IDX_W-1:0];
    assign walk_idx = tail_idx - rob_id_t'(1);
    assign count    = tail_ptr - head_ptr;
    assign empty    = (head_ptr == tail_ptr);
    assign full     = (head_idx == tail_idx) && (head_ptr[IDX_W] != tail_ptr[IDX_W]);
    assign alloc_id = tail_idx;
    assign dbg_state = state_q;

    always_comb begin
        head_ent     = mem_q[head_idx];
        walk_has_dst = mem_q[walk_idx].has_dst;
        in_run       = (state_q == TQ_RUN);
        head_ready   = in_run && valid_q[head_idx] && done_q[head_idx];
        walk_active  = !in_run && !empty;

        free_valid   = head_ready ? head_ent.has_dst : (walk_active && walk_has_dst);
        free_tag     = in_run ? head_ent.old_tag : mem_q[walk_idx].new_tag;
        retire       = head_ready && (!head_ent.has_dst || free_ready);
        walk_step    = walk_active && (!walk_has_dst || free_ready);
        commit_valid = head_ready && head_ent.has_dst && free_ready;
        commit_arch  = head_ent.arch;
        commit_tag   = head_ent.new_tag;

        alloc_ready  = in_run && !full && !flush;
        alloc_fire   = alloc_valid && alloc_ready;
    end

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (in_run && done_valid && valid_q[done_id]) done_d[done_id] = 1'b1;
        if (retire) valid_d[head_idx] = 1'b0;
        if (walk_step) begin
            valid_d[walk_idx] = 1'b0;
            done_d[walk_idx]  = 1'b0;
        end
        if (alloc_fire) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
        end

        count_d = count + CW'(alloc_fire) - CW'(retire) - CW'(walk_step);

        // The retire of the flush cycle still lands, so decide on the post-edge count.
        state_d = state_q;
        case (state_q)
            TQ_RUN:   if (flush && count_d != '0) state_d = TQ_FLUSH;
            TQ_FLUSH: if (count_d == '0) state_d = TQ_RUN;
            default:  state_d = TQ_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TQ_RUN;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            mem_q[tail_idx] <= '{has_dst: alloc_has_dst, arch: alloc_arch,
                                 new_tag: alloc_new_tag, old_tag: alloc_old_tag};
        end
    end
endmodule
